// File: rtl/icmp_rx.sv
// Receive-side ICMP parser: checks checksum and length of each datagram from the
// IP layer, pulses o_trigger on echo requests and o_reply_valid on echo replies.
module icmp_rx #(
  parameter logic [7:0] P_ICMP_PROTO = 8'd1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] s_axis_ip_data,
  input  logic [55:0] s_axis_ip_user,
  input  logic [7:0]  s_axis_ip_keep,
  input  logic        s_axis_ip_last,
  input  logic        s_axis_ip_valid,
  output logic        s_axis_ip_ready,
  output logic [15:0] o_Identifier,
  output logic [15:0] o_Sequence,
  output logic        o_trigger,
  output logic        o_reply_valid,
  output logic [15:0] o_rx_cnt,
  output logic [15:0] o_err_cnt
);

  // Handshake: a beat transfers on a rising edge where s_axis_ip_valid and
  // s_axis_ip_ready are both high; data/keep/last/user matter only then.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_BODY = 3'd1,
    S_CHK1 = 3'd2,
    S_CHK2 = 3'd3,
    S_DROP = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic        ready_q;
  logic [31:0] acc_q;
  logic [15:0] bytes_q;
  logic [15:0] len_q;
  logic [15:0] fold_q;
  logic [7:0]  type_q;
  logic [7:0]  code_q;
  logic [15:0] id_q;
  logic [15:0] seq_q;
  logic [15:0] ident_q;
  logic [15:0] sequ_q;
  logic        trigger_q;
  logic        reply_q;
  logic [15:0] rx_cnt_q;
  logic [15:0] err_cnt_q;

  logic        accept;
  logic        hdr_drop;
  logic [63:0] masked;
  logic [3:0]  keep_cnt;
  logic [31:0] beat_sum;
  logic [15:0] beat_bytes;
  logic [16:0] fold1;
  logic [15:0] fold2;
  logic        pkt_good;

  wire unused_user = ^{s_axis_ip_user[39:38], s_axis_ip_user[15:0]};

  assign accept   = s_axis_ip_valid & ready_q;
  assign hdr_drop = (s_axis_ip_user[36:29] != P_ICMP_PROTO) || s_axis_ip_user[37] ||
                    (s_axis_ip_user[28:16] != 13'd0);

  // Masked-off bytes count as zero, which also pads an odd trailing byte.
  always_comb begin
    masked   = '0;
    keep_cnt = '0;
    for (int i = 0; i < 8; i++) begin
      if (s_axis_ip_keep[i]) begin
        masked[i*8 +: 8] = s_axis_ip_data[i*8 +: 8];
        keep_cnt         = keep_cnt + 4'd1;
      end
    end
    beat_sum   = {16'd0, masked[63:48]} + {16'd0, masked[47:32]} +
                 {16'd0, masked[31:16]} + {16'd0, masked[15:0]};
    beat_bytes = s_axis_ip_last ? {12'd0, keep_cnt} : 16'd8;
  end

  always_comb begin
    fold1    = {1'b0, acc_q[15:0]} + {1'b0, acc_q[31:16]};
    fold2    = fold1[15:0] + {15'd0, fold1[16]};
    pkt_good = (fold_q == 16'hFFFF) && (bytes_q == len_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (hdr_drop) state_d = s_axis_ip_last ? S_IDLE : S_DROP;
          else          state_d = s_axis_ip_last ? S_CHK1 : S_BODY;
        end
      end
      S_BODY:  if (accept && s_axis_ip_last) state_d = S_CHK1;
      S_CHK1:  state_d = S_CHK2;
      S_CHK2:  state_d = S_IDLE;
      S_DROP:  if (accept && s_axis_ip_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b0;
      acc_q     <= '0;
      bytes_q   <= '0;
      len_q     <= '0;
      fold_q    <= '0;
      type_q    <= '0;
      code_q    <= '0;
      id_q      <= '0;
      seq_q     <= '0;
      ident_q   <= '0;
      sequ_q    <= '0;
      trigger_q <= 1'b0;
      reply_q   <= 1'b0;
      rx_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= (state_d == S_IDLE) || (state_d == S_BODY) || (state_d == S_DROP);
      trigger_q <= 1'b0;
      reply_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept && !hdr_drop) begin
            type_q  <= s_axis_ip_data[63:56];
            code_q  <= s_axis_ip_data[55:48];
            id_q    <= s_axis_ip_data[31:16];
            seq_q   <= s_axis_ip_data[15:0];
            len_q   <= s_axis_ip_user[55:40];
            acc_q   <= beat_sum;
            bytes_q <= beat_bytes;
          end
        end
        S_BODY: begin
          if (accept) begin
            acc_q   <= acc_q + beat_sum;
            bytes_q <= bytes_q + beat_bytes;
          end
        end
        S_CHK1: fold_q <= fold2;
        S_CHK2: begin
          if (pkt_good) begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
            if (code_q == 8'd0 && type_q == 8'd8) begin
              ident_q   <= id_q;
              sequ_q    <= seq_q;
              trigger_q <= 1'b1;
            end else if (code_q == 8'd0 && type_q == 8'd0) begin
              ident_q <= id_q;
              sequ_q  <= seq_q;
              reply_q <= 1'b1;
            end
          end else begin
            err_cnt_q <= err_cnt_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_axis_ip_ready = ready_q;
  assign o_Identifier    = ident_q;
  assign o_Sequence      = sequ_q;
  assign o_trigger       = trigger_q;
  assign o_reply_valid   = reply_q;
  assign o_rx_cnt        = rx_cnt_q;
  assign o_err_cnt       = err_cnt_q;

endmodule

// File: doc/icmp_rx.md
Name: icmp_rx

Overview:
Receive-side ICMP block. It consumes ICMP datagrams that the IP receive layer delivers over a 64-bit AXI-stream. For each datagram it parses the ICMP header, verifies the ones-complement checksum and the length. Accepted echo requests raise a one-cycle trigger carrying Identifier/Sequence; that trigger drives the ICMP transmitter's i_trigger/i_Identifier/i_Sequence directly to send a reply. Echo replies are reported separately. All other traffic is consumed and counted.

Parameters:
P_ICMP_PROTO, 8'd1, IP protocol value accepted as ICMP.

Ports:
i_clk  input  1  sole clock.
i_rst  input  1  asynchronous, active-high reset.
s_axis_ip_data  input  64  beat data; byte0 = [63:56].
s_axis_ip_user  input  56  {16 len, 3 flag, 8 type, 13 offset, 16 ID}; sampled on first beat. len = ICMP bytes.
s_axis_ip_keep  input  8  keep[7] = byte [63:56]; contiguous from MSB; all ones except possibly on the last beat.
s_axis_ip_last  input  1  final beat.
s_axis_ip_valid  input  1  beat valid.
s_axis_ip_ready  output  1  beat accepted when valid&ready.
o_Identifier  output  16  Identifier of the last accepted request/reply.
o_Sequence  output  16  Sequence of the last accepted request/reply.
o_trigger  output  1  one-cycle pulse: valid echo request (type 8, code 0).
o_reply_valid  output  1  one-cycle pulse: valid echo reply (type 0, code 0).
o_rx_cnt  output  16  count of good ICMP packets; wraps.
o_err_cnt  output  16  count of bad-checksum or length-mismatch ICMP packets; wraps.

Behaviour:
- Reset (async): all outputs 0, including s_axis_ip_ready; state IDLE; accumulators cleared. Reset mid-packet aborts the packet without any pulse or count. The first beat accepted after reset is treated as a header.
- ready is 1 in IDLE, BODY and DROP. It is 0 in CHK1 and CHK2.
- FSM:
  - IDLE, first beat accepted:
    - If user type ≠ P_ICMP_PROTO, or flag[0] (MF) = 1, or offset ≠ 0: go to DROP. DROP ignores everything including counters; go to IDLE on last.
    - Otherwise latch type=data[63:56], code=[55:48], ID=[31:16], SEQ=[15:0] and user len, and start the checksum.
    - Then go to CHK1 if last, else BODY.
  - BODY: accumulate each accepted beat; go to CHK1 on last.
  - CHK1: fold the 32-bit accumulator to 16 bits (add carries, twice).
  - CHK2: evaluate, then return to IDLE.
- Checksum:
  - Per beat, sum the four 16-bit words into a 32-bit accumulator.
  - Bytes with keep=0 contribute 0, so an odd trailing byte is padded with a zero low byte.
  - The packet is good when the folded sum = 16'hFFFF.
- Length: byte count = 8 × (non-last beats) + popcount(last keep). A mismatch with latched len is an error.
- Evaluation in CHK2 (registered outputs, visible the cycle after CHK2):
  - Good packet: o_rx_cnt +1.
  - Good, type 8, code 0: o_Identifier/o_Sequence updated and o_trigger=1 in the same cycle.
  - Good, type 0, code 0: o_Identifier/o_Sequence updated and o_reply_valid=1.
  - Other good types: counted only.
  - Bad packet: o_err_cnt +1 and no pulse.
- Latency: o_trigger high on the 3rd rising edge after the last-beat handshake edge. The next packet can be accepted 3 cycles after the previous last beat.
- Pulses are exactly 1 cycle. o_Identifier/o_Sequence hold their value until the next good request/reply.
- Counters wrap FFFF→0000.
- The valid/data/keep/last inputs are sampled only on handshake. Gaps in valid mid-packet are tolerated in any state.

Test Plan:
1. 1 beat, data 64'h0800F7FF00000000, user {16'd8,3'b010,8'd1,13'd0,16'd1}, keep FF, last → o_trigger pulse, ID=0000, SEQ=0000, o_rx_cnt=1.
2. 1 beat, data 64'h0800E5CA12340001 → o_trigger on the 3rd edge after the handshake, o_Identifier=16'h1234, o_Sequence=16'h0001; ready low exactly 2 cycles.
3. Same as 2 with checksum 16'hE5CB → no pulse, o_err_cnt=1, outputs hold. Then 5-beat echo reply (type 0, len 40), checksum computed by the bench, with valid gaps → o_reply_valid pulse only.
4. user type 8'd6 (TCP), and separately offset=13'd5 and MF=1 → packets consumed, ready stays 1 throughout, no pulse, counters unchanged.
5. 2-beat packet, len 13, last keep 8'b1111_1000, odd byte, correct checksum → accepted. Same packet with len 16 → o_err_cnt +1.
6. Assert i_rst mid-packet (beat 2 of 5) → outputs/ready 0 immediately, no pulse. The next fresh packet (scenario 2) is accepted normally. Preload o_rx_cnt to FFFF via 65535 packets (or force) → wraps to 0000.
